// File: rtl/operand_pkg.sv
// Shared operand-path definitions used by the mux side, this demux and the
// Vedic multiplier core.
package operand_pkg;

  // Default operand word width of the 8x8 Vedic core.
  localparam int OPERAND_WIDTH = 8;

  // Default number of demux lanes (A and B).
  localparam int DEMUX_LANES = 2;

  // FILL: collecting words; FULL: a complete set is held for the consumer.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } demux_state_e;

  // Width of a lane index; never below one bit so two lanes still get a
  // usable counter.
  function automatic int lane_idx_width(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One operand lane: a WIDTH-bit holding register with synchronous clear and
// load enable. The demux instantiates one of these per output lane.
module demux_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Capture the shared bus word only when this lane is selected.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  // Lane storage; cleared to zero so out_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/operand_demux.sv
// Time-division 1:LANES operand demultiplexer. Words arriving one at a time
// on the shared bus are steered into lane registers; once every lane holds a
// word of the current set, the set is offered to the multiplier through a
// valid/ready handshake.
module operand_demux
  import operand_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH,
  parameter int LANES = DEMUX_LANES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              in_valid,
  input  logic                              in_first,
  output logic                              in_ready,
  output logic [LANES*WIDTH-1:0]            out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              frame_err,
  output logic [lane_idx_width(LANES)-1:0]  lane_idx
);

  localparam int IDX_W = lane_idx_width(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  demux_state_e     state_q;
  demux_state_e     state_d;
  logic [IDX_W-1:0] lane_idx_q;
  logic [IDX_W-1:0] lane_idx_d;
  logic             frame_err_q;
  logic             frame_err_d;

  logic             in_fire;
  logic             out_fire;
  logic             resync;
  logic [IDX_W-1:0] wr_idx;
  logic [LANES-1:0] lane_load;

  // Handshake decode. in_ready only follows out_ready while a set is held,
  // which is what lets a new lane-0 word enter in the same cycle the held
  // set leaves.
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    // A first-word marker in the middle of a set restarts framing at lane 0.
    resync    = (state_q == FILL) & in_first & (lane_idx_q != '0);
    // Resync and the simultaneous-fire case both write lane 0.
    wr_idx    = (resync || (state_q == FULL)) ? '0 : lane_idx_q;
  end

  // Next-state, lane counter and sticky framing-error logic.
  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    frame_err_d = frame_err_q;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          if (resync) begin
            lane_idx_d  = ONE_IDX;
            frame_err_d = 1'b1;
          end else if (lane_idx_q == LAST_IDX) begin
            lane_idx_d = '0;
            state_d    = FULL;
          end else begin
            lane_idx_d = lane_idx_q + ONE_IDX;
          end
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d    = FILL;
          lane_idx_d = in_fire ? ONE_IDX : '0;
        end
      end
      default: begin
        state_d    = FILL;
        lane_idx_d = '0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      lane_idx_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      frame_err_q <= frame_err_d;
    end
  end

  // One lane register per output lane, each loaded when the write index
  // selects it.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_load[gi] = in_fire & (wr_idx == IDX_W'(gi));

    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_load[gi]),
      .d    (in_data),
      .q    (out_data[gi*WIDTH +: WIDTH])
    );
  end

  assign frame_err = frame_err_q;
  assign lane_idx  = lane_idx_q;

endmodule

// File: tb/tb_operand_demux.sv
// Bench for operand_demux: a 2-lane and a 4-lane instance share one input
// bus. A set-level model predicts every cycle's outputs, and directed
// scenarios pin hand-computed values.
module tb_operand_demux;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_first;
  logic        out_ready;

  logic        in_ready2;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic        frame_err2;
  logic [0:0]  lane_idx2;

  logic        in_ready4;
  logic [31:0] out_data4;
  logic        out_valid4;
  logic        frame_err4;
  logic [1:0]  lane_idx4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Model state: words collected so far, whether a set is held, lane contents.
  int         m_cnt  [2];
  bit         m_full [2];
  bit         m_err  [2];
  logic [7:0] m_lane [2][4];

  // Sets seen leaving each DUT, compared against literal lists.
  logic [31:0] sets2[$];
  logic [31:0] sets4[$];

  logic [7:0] w4 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  operand_demux #(.WIDTH(8), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .frame_err(frame_err2),
    .lane_idx(lane_idx2)
  );

  operand_demux #(.WIDTH(8), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .frame_err(frame_err4),
    .lane_idx(lane_idx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_data(input int m);
    logic [31:0] r;
    int n;
    r = '0;
    n = (m == 1) ? 4 : 2;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = m_lane[m][k];
    return r;
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("valid2", out_valid2, m_full[0]);
        check("ready2", in_ready2, !m_full[0] || out_ready);
        check("idx2", lane_idx2, m_cnt[0]);
        check("err2", frame_err2, m_err[0]);
        if (m_full[0]) check("data2", out_data2, model_data(0));
        check("valid4", out_valid4, m_full[1]);
        check("ready4", in_ready4, !m_full[1] || out_ready);
        check("idx4", lane_idx4, m_cnt[1]);
        check("err4", frame_err4, m_err[1]);
        if (m_full[1]) check("data4", out_data4, model_data(1));
        if (out_valid2 && out_ready) sets2.push_back({16'h0, out_data2});
        if (out_valid4 && out_ready) sets4.push_back(out_data4);
      end
      for (int m = 0; m < 2; m++) begin
        int n;
        bit inf;
        bit outf;
        n = (m == 1) ? 4 : 2;
        if (rst) begin
          m_cnt[m] = 0;
          m_full[m] = 0;
          m_err[m] = 0;
          for (int k = 0; k < 4; k++) m_lane[m][k] = 8'h00;
        end else begin
          outf = m_full[m] && out_ready;
          inf  = in_valid && (!m_full[m] || out_ready);
          if (m_full[m]) begin
            if (outf) begin
              m_full[m] = 0;
              m_cnt[m] = 0;
              if (inf) begin
                m_lane[m][0] = in_data;
                m_cnt[m] = 1;
              end
            end
          end else if (inf) begin
            if (in_first && m_cnt[m] != 0) begin
              m_err[m] = 1;
              m_lane[m][0] = in_data;
              m_cnt[m] = 1;
            end else begin
              m_lane[m][m_cnt[m]] = in_data;
              m_cnt[m]++;
              if (m_cnt[m] == n) begin
                m_cnt[m] = 0;
                m_full[m] = 1;
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    in_data  = d;
    in_valid = 1'b1;
    in_first = f;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sets2.delete();
    sets4.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_first = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid2, 1'b0);
    check("rst_ready", in_ready2, 1'b1);
    check("rst_idx", lane_idx2, 1'b0);
    check("rst_err", frame_err2, 1'b0);
    check("rst_data", out_data2, 16'h0000);
    check("rst_data4", out_data4, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic pair.
    do_reset();
    out_ready = 1'b1;
    send(8'h3C, 1'b1);
    send(8'hA5, 1'b0);
    check("pair_valid", out_valid2, 1'b1);
    check("pair_data", out_data2, 16'hA53C);
    tick();
    check("pair_back_fill", out_valid2, 1'b0);

    // Backpressure, then simultaneous fire.
    do_reset();
    out_ready = 1'b0;
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    in_data = 8'h56;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", in_ready2, 1'b0);
      check("bp_hold", out_data2, 16'h3412);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_up", in_ready2, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_idx", lane_idx2, 1'b1);
    check("bp_valid", out_valid2, 1'b0);
    check("bp_nsets", sets2.size(), 1);
    if (sets2.size() > 0) check("bp_set", sets2[0], 32'h3412);
    send(8'h78, 1'b0);
    check("bp_next", out_data2, 16'h7856);
    tick();

    // Back-to-back stream.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("b2b_nsets", sets2.size(), 4);
    if (sets2.size() == 4) begin
      check("b2b_s0", sets2[0], 32'h0201);
      check("b2b_s1", sets2[1], 32'h0403);
      check("b2b_s2", sets2[2], 32'h0605);
      check("b2b_s3", sets2[3], 32'h0807);
    end
    check("b2b_nsets4", sets4.size(), 2);
    if (sets4.size() == 2) begin
      check("b2b4_s0", sets4[0], 32'h04030201);
      check("b2b4_s1", sets4[1], 32'h08070605);
    end

    // Resync.
    do_reset();
    out_ready = 1'b1;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    check("rs_err", frame_err2, 1'b1);
    check("rs_idx", lane_idx2, 1'b1);
    check("rs_err4", frame_err4, 1'b1);
    send(8'h33, 1'b0);
    check("rs_valid", out_valid2, 1'b1);
    check("rs_data", out_data2, 16'h3322);
    tick();
    check("rs_sticky", frame_err2, 1'b1);

    // Reset mid-set and reset while a set is held.
    do_reset();
    out_ready = 1'b1;
    send(8'h77, 1'b1);
    rst = 1'b1;
    check("mr_valid_in", out_valid2, 1'b0);
    tick();
    rst = 1'b0;
    check("mr_idx", lane_idx2, 1'b0);
    check("mr_valid", out_valid2, 1'b0);
    send(8'h88, 1'b1);
    send(8'h99, 1'b0);
    check("mr_data", out_data2, 16'h9988);
    check("mr_valid2", out_valid2, 1'b1);
    check("mr_err", frame_err2, 1'b0);
    tick();
    out_ready = 1'b0;
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    check("hr_valid", out_valid2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hr_lost", out_valid2, 1'b0);
    check("hr_data", out_data2, 16'h0000);

    // Four lanes.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("l4_idx", lane_idx4, k);
      send(w4[k], k == 0);
    end
    check("l4_idx_wrap", lane_idx4, 2'd0);
    check("l4_valid", out_valid4, 1'b1);
    check("l4_data", out_data4, 32'hEFBEADDE);
    tick();
    check("l4_back_fill", out_valid4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_demux.md
# operand_demux

Time-division 1:LANES demultiplexer, the receive-side counterpart of the 2:1 operand mux. It accepts operand words one at a time on a single shared bus and steers each into its own lane register: lane 0 = A, lane 1 = B for the default two-lane case. When every lane has been filled, it presents the complete operand set in parallel to the Vedic multiplier core through a valid/ready handshake. It sits between the serial operand source and the multiplier input stage.

## Interface
Parameters:
- WIDTH, default 8: operand word width; matches the 8x8 Vedic core.
- LANES, default 2: number of output lanes; legal range 2..4.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  operand word on the shared bus.
- in_valid  in  1  in_data is valid this cycle.
- in_first  in  1  qualifies in_data as the lane-0 word of a new set; sampled only when in_valid=1.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a complete operand set.
- out_ready  in  1  downstream consumes out_data this cycle.
- frame_err  out  1  sticky; set when a set is resynchronised or a word is dropped; cleared only by rst.
- lane_idx  out  ceil(log2(LANES))  next lane to be written (debug/observability).

## Operation
- An input fire (in_fire) is in_valid & in_ready. An output fire (out_fire) is out_valid & out_ready.
- States:
  - FILL: collecting words; out_valid=0, in_ready=1.
  - FULL: complete set held; out_valid=1, in_ready=out_ready.
- FILL:
  - On in_fire, in_data is written to lane[lane_idx].
  - If lane_idx==LANES-1, lane_idx wraps to 0 and the state moves to FULL. Otherwise lane_idx increments.
- FULL:
  - Lane registers hold; out_data stays stable while out_valid=1.
  - out_fire without in_fire: go to FILL, lane_idx=0.
  - out_fire with in_fire in the same cycle: the word goes to lane 0, lane_idx=1, go to FILL. This gives full throughput.
- Resync: in_fire with in_first=1 while lane_idx!=0 (in FILL):
  - The partial set is discarded.
  - The word is written to lane 0 and lane_idx=1.
  - frame_err is set.
- in_fire with in_first=0 while lane_idx==0: the word is accepted normally as lane 0. in_first is optional framing.
- Lane registers not yet written in the current set keep stale contents. They are never exposed, because out_valid is asserted only after all lanes have been written.
- No arithmetic: words pass through unmodified; no width change per lane.

## Timing
- Reset values: out_valid=0, in_ready=1 (FILL), lane_idx=0, frame_err=0, out_data=0.
- rst mid-operation: aborts any partial or full set on the next edge and returns to reset values. A held set is lost.
- Latency: out_valid rises the cycle after the in_fire of the lane LANES-1 word.
- Minimum set period: LANES cycles with in_valid held high and out_ready held high (back-to-back via the simultaneous-fire rule).
- in_ready depends combinationally on out_ready in FULL only. There is no combinational path from in_valid to any output.
- out_valid must not drop without out_fire or rst.
- frame_err asserts the cycle after the offending in_fire.

## Structure
- Shared package operand_pkg:
  - OPERAND_WIDTH=8 and DEMUX_LANES=2 constants, shared with the mux side and the multiplier.
  - State enum {FILL, FULL}.
  - Lane-index width function.
- Sub-module demux_lane_reg: WIDTH-bit register with a synchronous clear (rst) and load enable (in_fire & lane_idx==k, or lane 0 on resync/simultaneous fire). Instantiate it LANES times.
- Top level holds the FSM, the lane_idx counter, the enable decode and frame_err.

## Test plan
- Basic pair (WIDTH=8, LANES=2): send 0x3C then 0xA5, with out_ready=1 → out_valid=1 one cycle after the second fire, out_data=0xA53C, then returns to FILL.
- Backpressure: fill with 0x12, 0x34 and hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0, out_data held at 0x3412. Raise out_ready with in_data=0x56 → both fire in the same cycle, next lane_idx=1.
- Back-to-back stream: 8 words 0x01..0x08 with in_valid and out_ready held high → four sets, 0x0201, 0x0403, 0x0605, 0x0807, with no bubbles.
- Resync: send 0x11 (in_first=1), then 0x22 with in_first=1 → frame_err=1, lane 0=0x22. Next word 0x33 completes set 0x3322.
- Reset mid-set: send 0x77, assert rst for 1 cycle, then send 0x88, 0x99 → out_data=0x9988, out_valid=0 during and after reset, frame_err=0.
- LANES=4 variant: send 0xDE, 0xAD, 0xBE, 0xEF → out_data=0xEFBEADDE, lane_idx sequence 0,1,2,3,0.
